// File: rtl/onehot2binary_enc.sv
// Combinational one-hot to binary encoder: the lowest set bit gives the index,
// with flags for an all-zero word and for a word with more than one bit set.
module onehot2binary_enc #(
    parameter int OH_WIDTH  = 16,
    parameter int BIN_WIDTH = 4
) (
    input  logic [OH_WIDTH-1:0]  i_dat,
    output logic [BIN_WIDTH-1:0] o_dat,
    output logic                 o_zero,
    output logic                 o_multi
);

    always_comb begin
        o_dat = '0;
        // Scan downwards so the lowest set bit is the last, winning assignment.
        for (int i = OH_WIDTH - 1; i >= 0; i--) begin
            if (i_dat[i]) begin
                o_dat = BIN_WIDTH'(i);
            end
        end
    end

    assign o_zero  = ~|i_dat;
    // Clearing the lowest set bit leaves something only if a second bit was set.
    assign o_multi = |(i_dat & (i_dat - OH_WIDTH'(1)));

endmodule

// File: rtl/onehot2binary_stream.sv
// Streaming one-hot to binary encoder: two-stage valid/ready pipeline with
// zero/multi-hot flags per word and a saturating count of flagged words.
module onehot2binary_stream #(
    parameter int BIN_WIDTH    = 4,
    parameter int OH_WIDTH     = 2**BIN_WIDTH,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OH_WIDTH-1:0]     i_dat,
    input  logic                    i_val,
    output logic                    i_rdy,
    output logic [BIN_WIDTH-1:0]    o_dat,
    output logic                    o_zero,
    output logic                    o_multi,
    output logic                    o_val,
    input  logic                    o_rdy,
    output logic [ERRCNT_WIDTH-1:0] err_cnt,
    input  logic                    err_clr
);

    if (OH_WIDTH > 2**BIN_WIDTH || OH_WIDTH < 2) begin : g_bad_params
        $error("onehot2binary_stream: OH_WIDTH must lie in [2, 2**BIN_WIDTH]");
    end

    // Handshake: a word moves across an interface on any clk edge where val and
    // rdy are both high; val never waits for rdy, and a held word stays stable.
    logic [OH_WIDTH-1:0]     r_dat1;
    logic                    r_v1;
    logic [BIN_WIDTH-1:0]    r_dat2;
    logic                    r_zero2;
    logic                    r_multi2;
    logic                    r_v2;
    logic [ERRCNT_WIDTH-1:0] r_err_cnt;

    logic                    w_adv1;
    logic                    w_adv2;
    logic [BIN_WIDTH-1:0]    w_enc_dat;
    logic                    w_enc_zero;
    logic                    w_enc_multi;
    logic                    w_err_xfer;

    // A stage may load when it is empty or its content leaves this cycle.
    assign w_adv2 = !r_v2 || o_rdy;
    assign w_adv1 = !r_v1 || w_adv2;

    onehot2binary_enc #(
        .OH_WIDTH  (OH_WIDTH),
        .BIN_WIDTH (BIN_WIDTH)
    ) u_enc (
        .i_dat   (r_dat1),
        .o_dat   (w_enc_dat),
        .o_zero  (w_enc_zero),
        .o_multi (w_enc_multi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_dat1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= i_val;
            if (i_val) begin
                r_dat1 <= i_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v2     <= 1'b0;
            r_dat2   <= '0;
            r_zero2  <= 1'b0;
            r_multi2 <= 1'b0;
        end else if (w_adv2) begin
            r_v2     <= r_v1;
            r_dat2   <= w_enc_dat;
            r_zero2  <= w_enc_zero;
            r_multi2 <= w_enc_multi;
        end
    end

    assign w_err_xfer = r_v2 && o_rdy && (r_zero2 || r_multi2);

    // Clear wins over a same-cycle error transfer.
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_xfer && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERRCNT_WIDTH'(1);
        end
    end

    assign i_rdy   = w_adv1;
    assign o_val   = r_v2;
    assign o_dat   = r_dat2;
    assign o_zero  = r_zero2;
    assign o_multi = r_multi2;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_onehot2binary_stream.sv
// Directed and random bench for onehot2binary_stream; a second instance with a
// 3-bit error counter shares the stimulus to exercise counter saturation.
module tb_onehot2binary_stream;

    localparam int BW   = 4;
    localparam int OW   = 16;
    localparam int EW   = 16;
    localparam int EXPW = BW + 2;   // {zero, multi, dat}

    logic          clk;
    logic          reset;
    logic [OW-1:0] i_dat;
    logic          i_val;
    logic          i_rdy;
    logic [BW-1:0] o_dat;
    logic          o_zero;
    logic          o_multi;
    logic          o_val;
    logic          o_rdy;
    logic [EW-1:0] err_cnt;
    logic          err_clr;

    logic          s_i_rdy;
    logic [BW-1:0] s_o_dat;
    logic          s_o_zero;
    logic          s_o_multi;
    logic          s_o_val;
    logic [2:0]    s_err_cnt;

    logic [EXPW-1:0] exp_q[$];
    logic [EW-1:0]   exp_err;
    logic [2:0]      exp_err_s;
    int              n_checks;
    int              n_errors;
    logic            model_push;
    logic            rnd_on;
    logic            lat_arm;
    logic            lat_wait;
    int              neg_cyc;
    int              lat_in;
    int              lat_out;

    onehot2binary_stream #(.BIN_WIDTH(BW), .OH_WIDTH(OW), .ERRCNT_WIDTH(EW)) u_dut (
        .clk(clk), .reset(reset), .i_dat(i_dat), .i_val(i_val), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_zero(o_zero), .o_multi(o_multi), .o_val(o_val),
        .o_rdy(o_rdy), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    onehot2binary_stream #(.BIN_WIDTH(BW), .OH_WIDTH(OW), .ERRCNT_WIDTH(3)) u_dut_sat (
        .clk(clk), .reset(reset), .i_dat(i_dat), .i_val(i_val), .i_rdy(s_i_rdy),
        .o_dat(s_o_dat), .o_zero(s_o_zero), .o_multi(s_o_multi), .o_val(s_o_val),
        .o_rdy(o_rdy), .err_cnt(s_err_cnt), .err_clr(err_clr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EXPW-1:0] ref_enc(input logic [OW-1:0] w);
        int          n;
        logic        found;
        logic [BW-1:0] idx;
        n     = $countones(w);
        found = 1'b0;
        idx   = '0;
        for (int b = 0; b < OW; b++) begin
            if (w[b] && !found) begin
                idx   = BW'(b);
                found = 1'b1;
            end
        end
        return {(n == 0), (n > 1), idx};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [OW-1:0] w);
        int waited;
        i_dat  = w;
        i_val  = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!i_rdy && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("send_rdy", 32'(i_rdy), 32'd1);
        @(posedge clk);
        #1;
        i_val = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            idle(1);
            t++;
        end
        idle(2);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        i_val   = 1'b0;
        err_clr = 1'b0;
        idle(3);
        reset = 1'b0;
    endtask

    function automatic logic [OW-1:0] rand_word();
        case ($urandom_range(0, 3))
            0, 1:    return OW'(1) << $urandom_range(0, OW - 1);
            2:       return '0;
            default: return OW'($urandom());
        endcase
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [EXPW-1:0] e;
        logic            popped;
        popped = 1'b0;
        e      = '0;
        neg_cyc++;
        if (reset) begin
            exp_q.delete();
            exp_err   = '0;
            exp_err_s = '0;
        end else begin
            if (lat_arm && i_val && i_rdy) begin
                lat_in   = neg_cyc;
                lat_arm  = 1'b0;
                lat_wait = 1'b1;
            end else if (lat_wait && o_val) begin
                lat_out  = neg_cyc;
                lat_wait = 1'b0;
            end
            if (o_val && o_rdy) begin
                check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e      = exp_q.pop_front();
                    popped = 1'b1;
                    check("o_dat", 32'(o_dat), 32'(e[BW-1:0]));
                    check("o_multi", 32'(o_multi), 32'(e[BW]));
                    check("o_zero", 32'(o_zero), 32'(e[BW+1]));
                    check("err_cnt", 32'(err_cnt), 32'(exp_err));
                    check("err_cnt_sat", 32'(s_err_cnt), 32'(exp_err_s));
                end
            end
            if (err_clr) begin
                exp_err   = '0;
                exp_err_s = '0;
            end else if (popped && (e[BW+1] || e[BW])) begin
                if (exp_err != '1)      exp_err   = exp_err + 1'b1;
                if (exp_err_s != 3'h7)  exp_err_s = exp_err_s + 1'b1;
            end
            if (model_push && i_val && i_rdy) begin
                exp_q.push_back(ref_enc(i_dat));
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            o_rdy   = 1'($urandom_range(0, 1));
            err_clr = ($urandom_range(0, 63) == 0);
        end
    end

    initial begin
        #5_000_000;
        check("watchdog", 32'd0, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [BW-1:0] hold_dat;
        int            t;
        n_checks = 0; n_errors = 0; neg_cyc = 0;
        lat_in = 0; lat_out = 0; lat_arm = 1'b0; lat_wait = 1'b0;
        model_push = 1'b0; rnd_on = 1'b0;
        exp_err = '0; exp_err_s = '0;
        i_dat = '0; o_rdy = 1'b0;
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_o_val", 32'(o_val), 32'd0);
        check("rst_o_dat", 32'(o_dat), 32'd0);
        check("rst_o_zero", 32'(o_zero), 32'd0);
        check("rst_o_multi", 32'(o_multi), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_i_rdy", 32'(i_rdy), 32'd1);
        @(posedge clk); #1;

        // sweep of every single-bit word, back to back
        o_rdy   = 1'b1;
        lat_arm = 1'b1;
        for (int k = 0; k < 16; k++) exp_q.push_back({2'b00, 4'(k)});
        for (int k = 0; k < 16; k++) send(OW'(1) << k);
        drain("sweep_drain");
        check("sweep_latency", 32'(lat_out - lat_in), 32'd2);
        check("sweep_err_cnt", 32'(err_cnt), 32'd0);

        // zero, multi-hot and top-bit words
        exp_q.push_back(6'b10_0000);
        exp_q.push_back(6'b01_0011);
        exp_q.push_back(6'b00_1111);
        send(16'h0000);
        send(16'h0028);
        send(16'h8000);
        drain("errw_drain");
        check("errw_err_cnt", 32'(err_cnt), 32'd2);

        // backpressure: o_rdy low for 5 clocks mid-stream
        for (int k = 0; k < 8; k++) exp_q.push_back({2'b00, 4'(k)});
        fork
            begin
                for (int k = 0; k < 8; k++) send(OW'(1) << k);
            end
            begin
                idle(3);
                o_rdy = 1'b0;
                @(negedge clk);
                hold_dat = o_dat;
                check("bp_o_val", 32'(o_val), 32'd1);
                repeat (4) begin
                    @(negedge clk);
                    check("bp_stable", 32'(o_dat), 32'(hold_dat));
                end
                check("bp_i_rdy", 32'(i_rdy), 32'd0);
                @(posedge clk); #1;
                o_rdy = 1'b1;
            end
        join
        drain("bp_drain");

        // random traffic against the reference model
        model_push = 1'b1;
        rnd_on     = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            send(rand_word());
        end
        rnd_on = 1'b0;
        idle(1);
        o_rdy   = 1'b1;
        err_clr = 1'b0;
        drain("rnd_drain");
        model_push = 1'b0;
        check("rnd_err_cnt", 32'(err_cnt), 32'(exp_err));
        check("rnd_err_cnt_sat", 32'(s_err_cnt), 32'(exp_err_s));

        // counter saturation with nine zero words
        do_reset();
        o_rdy = 1'b1;
        for (int k = 0; k < 9; k++) exp_q.push_back(6'b10_0000);
        for (int k = 0; k < 9; k++) send(16'h0000);
        drain("sat_drain");
        check("sat_err_cnt", 32'(s_err_cnt), 32'd7);
        check("sat_err_cnt_wide", 32'(err_cnt), 32'd9);

        // clear in the same cycle as an error transfer
        o_rdy = 1'b0;
        exp_q.push_back(6'b10_0000);
        send(16'h0000);
        t = 0;
        while (!o_val && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("clr_o_val", 32'(o_val), 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        o_rdy   = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_err_cnt_sat", 32'(s_err_cnt), 32'd0);
        drain("clr_drain");

        // reset with both stages full and the output stalled
        o_rdy = 1'b0;
        send(OW'(1) << 1);
        send(OW'(1) << 2);
        @(negedge clk);
        check("full_i_rdy", 32'(i_rdy), 32'd0);
        check("full_o_val", 32'(o_val), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        i_val = 1'b1;
        i_dat = OW'(1) << 5;
        @(posedge clk); #1;
        reset = 1'b0;
        i_val = 1'b0;
        o_rdy = 1'b1;
        @(negedge clk);
        check("mid_rst_o_val", 32'(o_val), 32'd0);
        check("mid_rst_i_rdy", 32'(i_rdy), 32'd1);
        idle(5);
        check("mid_rst_no_stale", 32'(o_val), 32'd0);
        exp_q.push_back({2'b00, 4'd9});
        send(OW'(1) << 9);
        drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/onehot2binary_stream.md
Name: onehot2binary_stream

Overview:
Streaming one-hot to binary encoder, the inverse of the team's binary-to-one-hot converter. It accepts one-hot words on a valid/ready interface and returns the binary index through a 2-stage pipeline that honours backpressure. Each output word is flagged when its input was not one-hot. A saturating error counter feeds status/CSR logic. It sits on the return path of one-hot-coded selects (grants, state vectors), where binary indices are needed for muxing or logging.

Parameters:
BIN_WIDTH, 4, binary index width
OH_WIDTH, 2**BIN_WIDTH, one-hot width; must satisfy 2 <= OH_WIDTH <= 2**BIN_WIDTH
ERRCNT_WIDTH, 16, width of the saturating error counter

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
i_dat  input  OH_WIDTH  one-hot input word
i_val  input  1  input word valid
i_rdy  output  1  block can accept the input word
o_dat  output  BIN_WIDTH  binary index
o_zero  output  1  input word was all-zero
o_multi  output  1  input word had more than one bit set
o_val  output  1  output valid
o_rdy  input  1  downstream accepts the output
err_cnt  output  ERRCNT_WIDTH  count of accepted non-one-hot words, saturating
err_clr  input  1  synchronous clear of err_cnt

Behaviour:
- One clock domain. Reset is synchronous and active-high; port names are clk and reset.
- Transfer rule: a word transfers when val && rdy on the same clk edge.
- Stage 1 registers i_dat and a valid bit v1. Stage 2 registers the encoded result and a valid bit v2 = o_val.
- Encoding is done in stage 2 from the stage-1 register:
  - o_dat = index of the lowest set bit.
  - o_zero = (word == 0); o_dat = 0 in that case.
  - o_multi = popcount > 1.
  - Bits at or above OH_WIDTH do not exist, so indices range from 0 to OH_WIDTH-1.
- Advance rules (bubble-collapsing, no combinational path from o_rdy except through the stage enables):
  - adv2 = !v2 || o_rdy
  - adv1 = !v1 || adv2
  - i_rdy = adv1
- On adv2: v2 <= v1, and the data/flags load from stage 1. On adv1: v1 <= i_val, and the data loads when i_val.
- Latency is 2 clk from input transfer to o_val with no stall. Throughput is 1 word/clk while o_rdy=1.
- When o_val=1 && o_rdy=0, o_dat, o_zero and o_multi hold stable. No word is dropped or duplicated, and order is preserved.
- err_cnt:
  - Increments by 1 when a word with (o_zero || o_multi) transfers on the output side (o_val && o_rdy).
  - Saturates at all-ones.
  - err_clr has priority: when err_clr=1 the counter becomes 0, and an error transfer in that same cycle is not counted.
- Reset values: v1=0, o_val=0, o_dat=0, o_zero=0, o_multi=0, err_cnt=0. i_rdy=1 from the first cycle after reset.
- Reset mid-operation: all in-flight words are discarded. i_val is ignored while reset=1.
- With i_val=0 the pipeline drains on o_rdy.
- Illegal parameters (OH_WIDTH > 2**BIN_WIDTH or OH_WIDTH < 2) trigger an elaboration-time $error.

Decomposition:
- No shared package needed. All widths are parameters; ERRCNT_WIDTH saturation is the local constant '1.
- One combinational sub-module, onehot2binary_enc (OH_WIDTH, BIN_WIDTH in; dat, zero, multi out). It holds a lowest-set-bit priority loop plus zero/multi detection, is reusable, and is instantiated between stage 1 and stage 2.
- The stream/pipeline control and the counter stay in the top module.

Test Plan:
- Sweep: after reset, o_rdy=1, i_val=1, i_dat = 1<<k for k=0..15 on back-to-back clocks. Required: o_dat = 0..15 in order, o_val first seen 2 clk after the first transfer, o_zero=o_multi=0, err_cnt=0.
- Error words: send 16'h0000, then 16'h0028, then 16'h8000. Required:
  - Word 1: o_dat=0, o_zero=1, o_multi=0.
  - Word 2: o_dat=3, o_zero=0, o_multi=1.
  - Word 3: o_dat=15, no flags.
  - err_cnt = 2 after all three transfer.
- Backpressure: stream 1<<0..1<<7 and hold o_rdy=0 for 5 clk mid-stream. Required:
  - i_rdy=0 once both stages are full.
  - o_dat is stable while stalled.
  - All 8 indices arrive exactly once, in order.
- Random o_rdy/i_val (50%) for 10k words against a reference model. Required: no loss, no duplication, matching flags and err_cnt.
- Counter edges, with ERRCNT_WIDTH=3 and 9 zero words. Required:
  - err_cnt saturates at 7.
  - err_clr=1 in the same cycle as an error transfer gives err_cnt=0.
- Reset with both stages full and o_rdy=0. Required: the next cycle has o_val=0 and i_rdy=1, and no stale word ever appears at the output.
